// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One shift-add or restore-subtract step
// runs per cycle. Results are registered with a one-cycle strobe, and a kill
// input abandons the operation in flight.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand for mul, divisor for div
  logic [2*XLEN-1:0] acc_q;    // {partial product | remainder, multiplier | quotient}
  logic [CW-1:0]     cnt;

  // ---------------- accept-side decode ----------------
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;

  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = op[2] && !op[0] && (a == SMIN) && (&b);
  assign special  = div_zero || div_ovf;
  // op[1] selects remainder among the divide ops
  assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // ---------------- one iteration step ----------------
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     msum, shl;
  logic              fits;
  logic [XLEN-1:0]   rem_n;
  logic [2*XLEN-1:0] mul_next, div_next, step_next;

  assign hi       = acc_q[2*XLEN-1:XLEN];
  assign lo       = acc_q[XLEN-1:0];
  assign msum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {msum, lo[XLEN-1:1]};

  assign shl      = {hi, lo[XLEN-1]};
  assign fits     = (shl >= {1'b0, opnd_q});
  // the difference always fits in XLEN bits because the remainder stays below the divisor
  assign rem_n    = fits ? (shl[XLEN-1:0] - opnd_q) : shl[XLEN-1:0];
  assign div_next = {rem_n, lo[XLEN-2:0], fits};

  assign step_next = op_q[2] ? div_next : mul_next;

  // ---------------- sign fix-up of the final step ----------------
  logic              neg_q;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, calc_res;

  assign neg_q  = sign_a_q ^ sign_b_q;
  assign prod_f = neg_q ? -step_next : step_next;
  assign quo_f  = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
  assign rem_f  = sign_a_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = rem_f;
    case (op_q)
      OP_MUL:                       calc_res = prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_res = quo_f;
      default:                      calc_res = rem_f;
    endcase
  end

  assign ready_out = (state == IDLE);

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in && !kill) begin
            op_q     <= op;
            sign_a_q <= sa;
            sign_b_q <= sb;
            cnt      <= CW'(XLEN);
            opnd_q   <= op[2] ? mag_b : mag_a;
            acc_q    <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            if (special) begin
              result    <= special_res;
              valid_out <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc_q <= step_next;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              result    <= calc_res;
              valid_out <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
